// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: registered FIFO between fetch and decode.
// The head entry falls through to decode. Define IFQ_PC_TAG_EN to store a PC tag with each entry.
module instr_fetch_queue #(
   parameter int unsigned INSTR_W = 16,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned PC_W    = 16
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     flush,
   input  logic                     in_valid,
   input  logic [INSTR_W-1:0]       in_instr,
`ifdef IFQ_PC_TAG_EN
   input  logic [PC_W-1:0]          in_pc,
`endif
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [INSTR_W-1:0]       out_instr,
`ifdef IFQ_PC_TAG_EN
   output logic [PC_W-1:0]          out_pc,
`endif
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
`ifdef IFQ_PC_TAG_EN
   localparam int unsigned ENTRY_W = PC_W + INSTR_W;
`else
   localparam int unsigned ENTRY_W = INSTR_W;
`endif

   // Reject illegal configurations at elaboration time.
   if (INSTR_W < 8 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || PC_W < 1) begin : g_bad_param
      $error("instr_fetch_queue: illegal parameter set");
   end

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [CW-1:0]      count;
   logic               push;
   logic               pop;
   logic [ENTRY_W-1:0] wr_entry;
   logic [ENTRY_W-1:0] head;

   // A pop never frees a slot for a push in the same cycle, and flush blocks intake.
   assign in_ready  = (count != CW'(DEPTH)) & ~flush;
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

`ifdef IFQ_PC_TAG_EN
   assign wr_entry  = {in_pc, in_instr};
`else
   assign wr_entry  = in_instr;
`endif

   // Head is masked to zero when empty so stale storage never reaches decode.
   assign head      = out_valid ? mem[rd_ptr] : '0;
   assign out_instr = head[INSTR_W-1:0];
`ifdef IFQ_PC_TAG_EN
   assign out_pc    = head[ENTRY_W-1 -: PC_W];
`endif
   assign level     = count;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage; push is already qualified by ~flush through in_ready.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else if (push) begin
         mem[wr_ptr] <= wr_entry;
      end
   end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue (INSTR_W=16, DEPTH=4).
// Checks the PC tag path when IFQ_PC_TAG_EN is defined.
module tb_instr_fetch_queue;

   localparam int unsigned INSTR_W = 16;
   localparam int unsigned DEPTH   = 4;
   localparam int unsigned PC_W    = 16;

   logic        clk;
   logic        rstn;
   logic        flush;
   logic        in_valid;
   logic [15:0] in_instr;
   logic        in_ready;
   logic        out_valid;
   logic [15:0] out_instr;
   logic        out_ready;
   logic [2:0]  level;
`ifdef IFQ_PC_TAG_EN
   logic [15:0] in_pc;
   logic [15:0] out_pc;
`endif

   logic [31:0] sb [$];
   int          n_checks;
   int          n_fails;

   instr_fetch_queue #(.INSTR_W(INSTR_W), .DEPTH(DEPTH), .PC_W(PC_W)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_instr  (in_instr),
`ifdef IFQ_PC_TAG_EN
      .in_pc     (in_pc),
`endif
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_instr (out_instr),
`ifdef IFQ_PC_TAG_EN
      .out_pc    (out_pc),
`endif
      .out_ready (out_ready),
      .level     (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Drive one cycle, check outputs mid-cycle against the model, then update the model at the edge.
   task automatic step(input logic iv, input logic [15:0] instr, input logic [15:0] pc,
                       input logic ordy, input logic fl);
      logic [31:0] hd;
      logic        exp_rdy;
      logic        do_push;
      logic        do_pop;
      in_valid  = iv;
      in_instr  = instr;
`ifdef IFQ_PC_TAG_EN
      in_pc     = pc;
`endif
      out_ready = ordy;
      flush     = fl;
      @(negedge clk);
      hd      = (sb.size() != 0) ? sb[0] : 32'h0;
      exp_rdy = (sb.size() != int'(DEPTH)) && !fl;
      check_eq("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      check_eq("level",     32'(level),     32'(sb.size()));
      check_eq("in_ready",  32'(in_ready),  32'(exp_rdy));
      check_eq("out_instr", 32'(out_instr), 32'(hd[15:0]));
`ifdef IFQ_PC_TAG_EN
      check_eq("out_pc",    32'(out_pc),    32'(hd[31:16]));
`endif
      do_push = iv && exp_rdy;
      do_pop  = ordy && (sb.size() != 0) && !fl;
      @(posedge clk);
      if (fl) begin
         sb.delete();
      end else begin
         if (do_pop)  void'(sb.pop_front());
         if (do_push) sb.push_back({pc, instr});
      end
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_out_valid"}, 32'(out_valid), 32'h0);
      check_eq({tag, "_out_instr"}, 32'(out_instr), 32'h0);
      check_eq({tag, "_level"},     32'(level),     32'h0);
      check_eq({tag, "_in_ready"},  32'(in_ready),  32'h1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks  = 0;
      n_fails   = 0;
      rstn      = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = '0;
      out_ready = 1'b0;
`ifdef IFQ_PC_TAG_EN
      in_pc     = '0;
`endif
      #2;
      check_reset_outputs("por");
      #10 rstn = 1'b1;
      @(posedge clk);
      #1;

      // Fill to full; the fifth push must be refused.
      for (int i = 0; i < 4; i++) step(1'b1, 16'(16'h1111 * (i + 1)), 16'(16'h0100 + i), 1'b0, 1'b0);
      step(1'b1, 16'h5555, 16'h0105, 1'b0, 1'b0);
      // Drain in order, then confirm nothing more comes out.
      repeat (6) step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);

      // Simultaneous push/pop streaming through pointer wrap.
      step(1'b1, 16'h9FFF, 16'h0200, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b1, 16'(16'hA000 + i), 16'(16'h0201 + i), 1'b1, 1'b0);
      repeat (2) step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);

      // Flush with a concurrent push and pop; 0xBEEF must never surface.
      for (int i = 0; i < 3; i++) step(1'b1, 16'(16'hB001 + i), 16'(16'h0300 + i), 1'b0, 1'b0);
      step(1'b1, 16'hBEEF, 16'h0333, 1'b1, 1'b1);
      step(1'b1, 16'hC0DE, 16'h0340, 1'b0, 1'b0);
      step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
      step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);

      // PC tag travels with its instruction.
      step(1'b1, 16'h1234, 16'h0040, 1'b0, 1'b0);
      step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

      // Asynchronous reset mid-stream with level=3.
      for (int i = 0; i < 3; i++) step(1'b1, 16'(16'hD001 + i), 16'(16'h0400 + i), 1'b0, 1'b0);
      in_valid = 1'b0;
      #2 rstn = 1'b0;
      #1;
      check_reset_outputs("midrst");
      sb.delete();
      @(negedge clk);
      #2 rstn = 1'b1;
      @(posedge clk);
      #1;
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

      // Random traffic including full-with-pop and occasional flushes.
      repeat (300) step(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                        1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
      repeat (6) step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
